// File: rtl/multi_timer.sv
`default_nettype none
// ============================================================================
// Module      : multi_timer
// Description : Multi-channel countdown timer with memory-mapped registers.
//               Each channel has CTRL / PRESET / COUNT / STATUS registers and
//               supports one-shot and periodic (auto-reload) operation.
//               PEND is sticky and cleared by writing 1. Interrupts are
//               available per channel and as a single ORed line.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_timer #(
    parameter int N_CH  = 2,
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [5:2]      addr,
    input  logic [31:0]     din,
    output logic [31:0]     dout,
    output logic [N_CH-1:0] irq_vec,
    output logic            irq
);

    // Register offsets within a channel's four-word window
    localparam logic [1:0] c_REG_CTRL   = 2'd0;
    localparam logic [1:0] c_REG_PRESET = 2'd1;
    localparam logic [1:0] c_REG_COUNT  = 2'd2;
    localparam logic [1:0] c_REG_STATUS = 2'd3;

    // CTRL.MODE encoding; anything other than periodic behaves as one-shot
    localparam logic [1:0] c_MODE_PERIODIC = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2
    } state_t;

    logic [1:0]  w_ch;
    logic [1:0]  w_reg;
    logic [31:0] w_rd_word [N_CH];
    logic [N_CH-1:0] w_irq;
    logic        w_unused_din;

    assign w_ch  = addr[5:4];
    assign w_reg = addr[3:2];

    // Upper data bits are only meaningful for wide presets
    assign w_unused_din = ^din;

    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_ch
            logic             w_sel;
            logic             w_ctrl_wr;
            logic             w_preset_wr;
            logic             w_stat_clr;
            state_t           r_state;
            state_t           w_state_nxt;
            logic             r_en;
            logic [1:0]       r_mode;
            logic             r_im;
            logic [WIDTH-1:0] r_preset;
            logic [WIDTH-1:0] r_count;
            logic [WIDTH-1:0] w_count_nxt;
            logic             r_pend;
            logic             w_pend_set;
            logic             w_hw_dis;
            logic [31:0]      w_rd;

            assign w_sel       = we && (w_ch == 2'(c));
            assign w_ctrl_wr   = w_sel && (w_reg == c_REG_CTRL);
            assign w_preset_wr = w_sel && (w_reg == c_REG_PRESET);
            assign w_stat_clr  = w_sel && (w_reg == c_REG_STATUS) && din[0];

            // FSM state and counter register
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state <= ST_IDLE;
                    r_count <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    r_count <= w_count_nxt;
                end
            end

            // Next-state, counter update and expiry detection
            always_comb begin
                w_state_nxt = r_state;
                w_count_nxt = r_count;
                w_pend_set  = 1'b0;
                w_hw_dis    = 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        if (r_en) begin
                            w_state_nxt = ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        w_count_nxt = r_preset;
                        w_state_nxt = ST_CNT;
                    end
                    ST_CNT: begin
                        if (!r_en) begin
                            w_state_nxt = ST_IDLE;
                        end else if (r_count == '0) begin
                            w_pend_set = 1'b1;
                            if (r_mode == c_MODE_PERIODIC) begin
                                w_count_nxt = r_preset;
                            end else begin
                                w_hw_dis    = 1'b1;
                                w_state_nxt = ST_IDLE;
                            end
                        end else begin
                            w_count_nxt = r_count - WIDTH'(1);
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end

            // CTRL register; a software write beats the one-shot auto-disable
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_en   <= 1'b0;
                    r_mode <= 2'b00;
                    r_im   <= 1'b0;
                end else if (w_ctrl_wr) begin
                    r_en   <= din[0];
                    r_mode <= din[2:1];
                    r_im   <= din[3];
                end else if (w_hw_dis) begin
                    r_en   <= 1'b0;
                end
            end

            // PRESET register; only sampled by LOAD and periodic reload
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_preset <= '0;
                end else if (w_preset_wr) begin
                    r_preset <= din[WIDTH-1:0];
                end
            end

            // Sticky PEND; a set on expiry wins over a simultaneous clear
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pend <= 1'b0;
                end else if (w_pend_set) begin
                    r_pend <= 1'b1;
                end else if (w_stat_clr) begin
                    r_pend <= 1'b0;
                end
            end

            // Per-channel read-back word, zero-extended
            always_comb begin
                w_rd = '0;
                case (w_reg)
                    c_REG_CTRL:   w_rd = {28'd0, r_im, r_mode, r_en};
                    c_REG_PRESET: w_rd = 32'(r_preset);
                    c_REG_COUNT:  w_rd = 32'(r_count);
                    c_REG_STATUS: w_rd = {31'd0, r_pend};
                    default:      w_rd = '0;
                endcase
            end

            assign w_rd_word[c] = w_rd;
            assign w_irq[c]     = r_pend & r_im;
        end
    endgenerate

    // Read mux; unpopulated channels and reset read as zero
    always_comb begin
        dout = '0;
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_ch == 2'(i)) begin
                    dout = w_rd_word[i];
                end
            end
        end
    end

    assign irq_vec = rst ? '0 : w_irq;
    assign irq     = |irq_vec;

endmodule
`default_nettype wire
